seg_pipe_adder: RTL
===================

// Module: seg_pipe_adder
//
// PURPOSE
//  Parametrised, pipelined signed/unsigned adder-subtractor, successor to four_adder.
//  - Splits WIDTH-bit operands into SEG-bit segments.
//  - Resolves one segment per clock, with a registered carry between stages.
//  - Accepts one operation per cycle and uses a valid/ready handshake with backpressure.
//  - Sits between operand registers and the result bus of the datapath.
//
// PARAMETERS
//  WIDTH  16  operand/result width in bits; WIDTH % SEG == 0 required
//  SEG     4  segment width per pipeline stage; NSTG = WIDTH/SEG stages (NSTG >= 1)
//
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands present this cycle
//  in_ready   out  1      block can accept operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in, used in add mode only
//  sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1), cin ignored
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result this cycle
//  s          out  WIDTH  sum/difference, modulo 2^WIDTH
//  c          out  1      carry-out of the MSB; in sub mode 1 = no borrow (a >= b unsigned)
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
//  - Reset: all stage valid bits cleared. out_valid=0, s=0, c=0, ovf=0, in_ready=1.
//    Reset applies immediately and asynchronously. An in-flight operation is discarded, never emitted.
//  - Accept: an operation is taken on a clk edge where in_valid && in_ready.
//  - Stall: stall = out_valid && !out_ready. in_ready = !stall.
//    During a stall every stage register, including outputs, holds its value.
//  - Stage 0 (at accept):
//    - computes segment 0 = a[SEG-1:0] + b'[SEG-1:0] + c0,
//      where b' = sub ? ~b : b and c0 = sub ? 1 : cin;
//    - registers the SEG-bit result and the carry;
//    - forwards the upper a/b' segments and the sub flag.
//  - Stage k (1..NSTG-1): adds segment k of the forwarded operands plus the registered carry of stage k-1.
//    Lower result segments are forwarded unchanged.
//  - Latency: result appears NSTG cycles after accept (out_valid rises on the NSTG-th edge).
//    There are no bubbles inserted when unstalled; throughput is 1 op/clk.
//  - ovf: taken from the final stage as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
//  - NSTG == 1 degenerates to a single registered adder with 1-cycle latency.
//  - Bubbles (no in_valid) propagate as cleared valid bits; s/c/ovf hold their last values when out_valid=0.
//  - Simultaneous accept and output pop in the same cycle is legal and must not lose or duplicate data.
//  - Operands are sampled only at accept; input changes while in_ready=0 have no effect.
//
// TESTING (WIDTH=16, SEG=4, NSTG=4)
//  1. Basic add: a=8, b=9, cin=0, sub=0, out_ready=1 -> 4 cycles later s=0x0011, c=0, ovf=0, out_valid for 1 cycle.
//  2. Full carry ripple: a=0xFFFF, b=0x0001 -> s=0x0000, c=1, ovf=0.
//     Then a=0x7FFF, b=0x0001 -> s=0x8000, c=0, ovf=1.
//  3. Subtract:
//     - a=5, b=9, sub=1 -> s=0xFFFC, c=0 (borrow), ovf=0;
//     - a=0x8000, b=1, sub=1 -> s=0x7FFF, c=1, ovf=1.
//  4. Throughput and stall:
//     - Drive 8 back-to-back ops (a=i, b=15, cin=1), out_ready=1 -> results i+16 on consecutive cycles.
//     - Repeat with out_ready=0 for cycles 6-8 -> in_ready=0 in those cycles, no result lost or duplicated, order preserved.
//  5. Reset mid-operation: accept 2 ops, assert rst_n=0 for 1 cycle before either emerges -> out_valid never rises, outputs 0.
//     Next op after release completes normally in 4 cycles.
//  6. Randomised: 10k random a/b/cin/sub with random out_ready -> compare s/c/ovf against a scoreboard reference model, in order.

Source files
------------

// File: rtl/seg_pipe_adder.sv
// Pipelined adder/subtractor: resolves one SEG-bit segment per stage, with a registered carry
// between stages and a valid/ready handshake. WIDTH must be a multiple of SEG.
module seg_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int NSTG = WIDTH / SEG;

  // The whole pipe advances together; a full, unconsumed output freezes every stage.
  logic w_adv;
  assign w_adv = !(g_stg[NSTG-1].r_v && !out_ready);

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    // Stage k sees only the operand bits it has not consumed yet, with its segment at the LSB,
    // and emits the low (k+1) segments of the result.
    localparam int IW = WIDTH - k * SEG;
    localparam int RW = (k + 1) * SEG;

    logic [IW-1:0] w_a;
    logic [IW-1:0] w_b;
    logic          w_cin;
    logic          w_v;
    logic [SEG:0]  w_sum;
    logic [RW-1:0] w_res;

    logic          r_v;
    logic          r_cy;
    logic [RW-1:0] r_s;

    if (k == 0) begin : g_in
      assign w_a   = a;
      assign w_b   = sub ? ~b : b;
      assign w_cin = sub | cin;
      assign w_v   = in_valid;
      assign w_res = w_sum[SEG-1:0];
    end else begin : g_in
      assign w_a   = g_stg[k-1].g_fwd.r_a;
      assign w_b   = g_stg[k-1].g_fwd.r_b;
      assign w_cin = g_stg[k-1].r_cy;
      assign w_v   = g_stg[k-1].r_v;
      assign w_res = {w_sum[SEG-1:0], g_stg[k-1].r_s};
    end

    assign w_sum = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_cin};

    // NOTE: state registers use non-blocking assignments so every stage samples the
    // pre-edge value of its predecessor; blocking here would collapse the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v  <= 1'b0;
        r_cy <= 1'b0;
        r_s  <= '0;
      end else if (w_adv) begin
        r_v <= w_v;
        if (w_v) begin
          r_cy <= w_sum[SEG];
          r_s  <= w_res;
        end
      end
    end

    if (k < NSTG - 1) begin : g_fwd
      logic [IW-SEG-1:0] r_a;
      logic [IW-SEG-1:0] r_b;

      // NOTE: forwarded operand bits carry no reset; they are only consumed alongside a
      // set valid bit, and the valid bits are what the reset clears.
      always_ff @(posedge clk) begin
        if (w_adv && w_v) begin
          r_a <= w_a[IW-1:SEG];
          r_b <= w_b[IW-1:SEG];
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Carry into the MSB is a^b^sum at that bit; XOR with the carry out gives signed overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_v) begin
          r_ovf <= w_a[SEG-1] ^ w_b[SEG-1] ^ w_sum[SEG-1] ^ w_sum[SEG];
        end
      end
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = g_stg[NSTG-1].r_v;
  assign s         = g_stg[NSTG-1].r_s;
  assign c         = g_stg[NSTG-1].r_cy;
  assign ovf       = g_stg[NSTG-1].g_last.r_ovf;

endmodule
